// File: rtl/aes_hakem.sv
// aes_hakem: two-requester round-robin front end for aes_engine.
// Requests are arbitrated into a single issue register and tagged with their
// owner. Tags queue up in issue order, and each engine result is matched to its
// tag and stored in a result FIFO. The result at the head of that FIFO is
// presented only to its owner. A credit counter caps the number of blocks in
// flight, so the engine, which has no backpressure, can never overrun the FIFOs.
module aes_hakem #(
  parameter int DERINLIK = 16,
  parameter int AW       = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [127:0]   req0_blok,
  input  logic [127:0]   req0_anahtar,
  input  logic           req0_gecerli,
  output logic           req0_hazir,
  input  logic [127:0]   req1_blok,
  input  logic [127:0]   req1_anahtar,
  input  logic           req1_gecerli,
  output logic           req1_hazir,
  output logic [127:0]   eng_blok,
  output logic [127:0]   eng_anahtar,
  output logic           eng_g_gecerli,
  input  logic           eng_hazir,
  input  logic [127:0]   eng_sifre,
  input  logic           eng_c_gecerli,
  output logic [127:0]   rsp0_sifre,
  output logic           rsp0_gecerli,
  input  logic           rsp0_hazir,
  output logic [127:0]   rsp1_sifre,
  output logic           rsp1_gecerli,
  input  logic           rsp1_hazir,
  output logic [AW:0]    aktif_sayisi,
  output logic           hata
);

  localparam logic [AW:0]   LP_MAX   = (AW+1)'(DERINLIK);
  localparam logic [AW:0]   LP_ONE_C = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] LP_ONE_P = {{(AW-1){1'b0}}, 1'b1};

  // Issue stage, round-robin preference and credit counter
  logic [127:0] r_stageBlok;
  logic [127:0] r_stageAnahtar;
  logic         r_stageTag;
  logic         r_engGecerli;
  logic         r_pref;
  logic [AW:0]  r_aktif;
  logic         r_hata;

  // Tag FIFO, one bit per block handed to the engine
  logic         r_tagMem [DERINLIK];
  logic [AW-1:0] r_tagWr;
  logic [AW-1:0] r_tagRd;
  logic [AW:0]  r_tagCnt;

  // Result FIFO, {tag, sifre} per completed block
  logic [128:0] r_resMem [DERINLIK];
  logic [AW-1:0] r_resWr;
  logic [AW-1:0] r_resRd;
  logic [AW:0]  r_resCnt;

  logic         w_slotBos;
  logic         w_kredi;
  logic         w_canGrant;
  logic         w_grant0;
  logic         w_grant1;
  logic         w_accept;
  logic         w_engHs;
  logic         w_tagEmpty;
  logic         w_resWr;
  logic         w_resValid;
  logic [128:0] w_head;
  logic         w_resPop;

  // The reset term keeps both ready outputs low while reset is held.
  assign w_slotBos  = !r_engGecerli || eng_hazir;
  assign w_kredi    = r_aktif < LP_MAX;
  assign w_canGrant = w_slotBos && w_kredi && rst;
  assign w_engHs    = r_engGecerli && eng_hazir;
  assign w_tagEmpty = (r_tagCnt == '0);
  assign w_resWr    = eng_c_gecerli && !w_tagEmpty;
  assign w_resValid = (r_resCnt != '0);
  assign w_head     = r_resMem[r_resRd];

  // Arbitration: a lone requester wins; when both ask, the preferred one wins
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (w_canGrant) begin
      if (req0_gecerli && req1_gecerli) begin
        if (r_pref) w_grant1 = 1'b1;
        else        w_grant0 = 1'b1;
      end else if (req0_gecerli) begin
        w_grant0 = 1'b1;
      end else if (req1_gecerli) begin
        w_grant1 = 1'b1;
      end
    end
  end

  assign w_accept   = w_grant0 || w_grant1;
  assign req0_hazir = w_grant0;
  assign req1_hazir = w_grant1;

  // The head result goes only to its owner; sifre is zero when nothing is shown
  assign rsp0_gecerli = w_resValid && !w_head[128];
  assign rsp1_gecerli = w_resValid &&  w_head[128];
  assign rsp0_sifre   = rsp0_gecerli ? w_head[127:0] : '0;
  assign rsp1_sifre   = rsp1_gecerli ? w_head[127:0] : '0;
  assign w_resPop     = (rsp0_gecerli && rsp0_hazir) || (rsp1_gecerli && rsp1_hazir);

  assign eng_blok      = r_stageBlok;
  assign eng_anahtar   = r_stageAnahtar;
  assign eng_g_gecerli = r_engGecerli;
  assign aktif_sayisi  = r_aktif;
  assign hata          = r_hata;

  // Issue register: load on accept, otherwise hold until the engine takes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stageBlok    <= '0;
      r_stageAnahtar <= '0;
      r_stageTag     <= 1'b0;
      r_engGecerli   <= 1'b0;
    end else if (w_accept) begin
      r_stageBlok    <= w_grant1 ? req1_blok    : req0_blok;
      r_stageAnahtar <= w_grant1 ? req1_anahtar : req0_anahtar;
      r_stageTag     <= w_grant1;
      r_engGecerli   <= 1'b1;
    end else if (eng_hazir) begin
      r_engGecerli   <= 1'b0;
    end
  end

  // Preference flips away from whoever was granted last
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_pref <= 1'b0;
    else if (w_accept) r_pref <= w_grant0;
  end

  // Blocks in flight: accepted but not yet handed back to a requester
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_aktif <= '0;
    end else begin
      case ({w_accept, w_resPop})
        2'b10:   r_aktif <= r_aktif + LP_ONE_C;
        2'b01:   r_aktif <= r_aktif - LP_ONE_C;
        default: r_aktif <= r_aktif;
      endcase
    end
  end

  // Sticky flag for an engine result that has no outstanding tag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             r_hata <= 1'b0;
    else if (eng_c_gecerli && w_tagEmpty) r_hata <= 1'b1;
  end

  // Tag FIFO storage, written on each engine handshake
  always_ff @(posedge clk) begin
    if (w_engHs) r_tagMem[r_tagWr] <= r_stageTag;
  end

  // Tag FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tagWr  <= '0;
      r_tagRd  <= '0;
      r_tagCnt <= '0;
    end else begin
      if (w_engHs) r_tagWr <= r_tagWr + LP_ONE_P;
      if (w_resWr) r_tagRd <= r_tagRd + LP_ONE_P;
      case ({w_engHs, w_resWr})
        2'b10:   r_tagCnt <= r_tagCnt + LP_ONE_C;
        2'b01:   r_tagCnt <= r_tagCnt - LP_ONE_C;
        default: r_tagCnt <= r_tagCnt;
      endcase
    end
  end

  // Result FIFO storage, written with the tag popped for this result
  always_ff @(posedge clk) begin
    if (w_resWr) r_resMem[r_resWr] <= {r_tagMem[r_tagRd], eng_sifre};
  end

  // Result FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_resWr  <= '0;
      r_resRd  <= '0;
      r_resCnt <= '0;
    end else begin
      if (w_resWr)  r_resWr <= r_resWr + LP_ONE_P;
      if (w_resPop) r_resRd <= r_resRd + LP_ONE_P;
      case ({w_resWr, w_resPop})
        2'b10:   r_resCnt <= r_resCnt + LP_ONE_C;
        2'b01:   r_resCnt <= r_resCnt - LP_ONE_C;
        default: r_resCnt <= r_resCnt;
      endcase
    end
  end

endmodule
